// File: rtl/countdown_display_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module : countdown_pkg
// Brief  : State encoding, 7-segment glyph constants and BCD digit lookup
//          for the countdown display timer.
// Rev    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COUNT      = 2'd1,
        SHOW_SCORE = 2'd2,
        SHOW_OVER  = 2'd3
    } state_t;

    // Segment order is dp,g,f,e,d,c,b,a (active-high)
    localparam logic [7:0] G_BLANK = 8'h00;
    localparam logic [7:0] G_DASH  = 8'h40;
    localparam logic [7:0] G_O     = 8'h3F;
    localparam logic [7:0] G_V     = 8'h3E;
    localparam logic [7:0] G_E     = 8'h79;
    localparam logic [7:0] G_R     = 8'h50;
    localparam logic [7:0] G_ERR   = 8'h80;

    function automatic logic [7:0] digit_glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return G_ERR;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_display_timer_bcd.sv
`default_nettype none
// ============================================================================
// Module : bcd_down_counter
// Brief  : N-digit BCD register with parallel load and single-cycle
//          decrement-with-borrow across all digits.
// Rev    : 1.0 - initial release
// ============================================================================
module bcd_down_counter #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    dec,
    output logic                    is_zero,
    output logic [4*NUM_DIGITS-1:0] value
);

    logic [4*NUM_DIGITS-1:0] value_r;
    logic [4*NUM_DIGITS-1:0] dec_value;
    logic                    borrow;

    // Ripple the borrow from the LSD upward; digits below the first nonzero become 9
    always_comb begin
        borrow    = 1'b1;
        dec_value = value_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (value_r[4*i +: 4] == 4'd0) begin
                    dec_value[4*i +: 4] = 4'd9;
                end else begin
                    dec_value[4*i +: 4] = value_r[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= '0;
        end else if (load) begin
            value_r <= load_value;
        end else if (dec) begin
            value_r <= dec_value;
        end
    end

    assign is_zero = (value_r == '0);
    assign value   = value_r;

endmodule
`default_nettype wire

// File: rtl/countdown_display_timer.sv
`default_nettype none
// ============================================================================
// Module : countdown_display_timer
// Brief  : Reaction-timer core: BCD countdown after a start press, then a
//          scrolling score or "OVEr" message on one 7-segment output.
// Rev    : 1.0 - initial release
// ============================================================================
module countdown_display_timer
    import countdown_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int SHOW_DIV   = 10000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    press,
    input  logic [3:0]              load_msd,
    output logic [7:0]              seg,
    output logic                    busy,
    output logic                    expired,
    output logic [4*NUM_DIGITS-1:0] score
);

    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int SHW_W  = $clog2(SHOW_DIV);
    localparam int SLOT_W = 4;
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [SHW_W-1:0]  SHW_LAST   = SHW_W'(SHOW_DIV - 1);
    localparam logic [SLOT_W-1:0] SCORE_LAST = SLOT_W'(NUM_DIGITS);
    localparam logic [SLOT_W-1:0] OVER_LAST  = SLOT_W'(4);

    state_t                  state;
    state_t                  next_state;
    logic                    press_q;
    logic                    press_rise;
    logic [PRE_W-1:0]        prescaler;
    logic                    tick;
    logic [SHW_W-1:0]        show_timer;
    logic [SLOT_W-1:0]       slot;
    logic [SLOT_W-1:0]       slot_last;
    logic                    in_show;
    logic                    load;
    logic                    dec;
    logic                    is_zero;
    logic [4*NUM_DIGITS-1:0] load_value;
    logic [3:0]              digit_sel;
    logic [7:0]              seg_d;

    assign press_rise = press & ~press_q;
    assign tick       = (prescaler == PRE_LAST);
    assign in_show    = (state == SHOW_SCORE) || (state == SHOW_OVER);

    always_comb begin
        load_value = {NUM_DIGITS{4'h9}};
        load_value[4*NUM_DIGITS-1 -: 4] = (load_msd > 4'd9) ? 4'd9 : load_msd;
    end

    bcd_down_counter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .dec        (dec),
        .is_zero    (is_zero),
        .value      (score)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Expiry is checked before the stop press so a simultaneous press loses
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (press_rise) next_state = COUNT;
            COUNT: begin
                if (tick && is_zero) begin
                    next_state = SHOW_OVER;
                end else if (press_rise) begin
                    next_state = SHOW_SCORE;
                end
            end
            SHOW_SCORE,
            SHOW_OVER:  if (press_rise) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == COUNT);
        expired   = (state == SHOW_OVER);
        load      = (state == IDLE) && press_rise;
        dec       = (state == COUNT) && tick && !is_zero && !press_rise;
        slot_last = (state == SHOW_OVER) ? OVER_LAST : SCORE_LAST;
        digit_sel = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot == SLOT_W'(NUM_DIGITS - i)) digit_sel = score[4*i +: 4];
        end
        seg_d = G_DASH;
        case (state)
            SHOW_SCORE: seg_d = (slot == '0) ? G_BLANK : digit_glyph(digit_sel);
            SHOW_OVER: begin
                case (slot)
                    4'd0:    seg_d = G_BLANK;
                    4'd1:    seg_d = G_O;
                    4'd2:    seg_d = G_V;
                    4'd3:    seg_d = G_E;
                    default: seg_d = G_R;
                endcase
            end
            default:    seg_d = G_DASH;
        endcase
    end

    // Slot sequencer restarts from the blank glyph on every entry to a SHOW state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_q    <= 1'b0;
            prescaler  <= '0;
            show_timer <= '0;
            slot       <= '0;
            seg        <= G_DASH;
        end else begin
            press_q   <= press;
            prescaler <= ((state == COUNT) && !tick) ? prescaler + 1'b1 : '0;
            seg       <= seg_d;
            if (in_show && (next_state == state)) begin
                if (show_timer == SHW_LAST) begin
                    show_timer <= '0;
                    slot       <= (slot == slot_last) ? '0 : slot + 1'b1;
                end else begin
                    show_timer <= show_timer + 1'b1;
                end
            end else begin
                show_timer <= '0;
                slot       <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_countdown_display_timer.sv
`default_nettype none
// ============================================================================
// Module : tb_countdown_display_timer
// Brief  : Self-checking bench with a cycle-level behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_countdown_display_timer;

    localparam int N  = 2;
    localparam int TD = 4;
    localparam int SD = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           press;
    logic [3:0]     load_msd;
    logic [7:0]     seg;
    logic           busy;
    logic           expired;
    logic [4*N-1:0] score;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    countdown_display_timer #(
        .NUM_DIGITS (N),
        .TICK_DIV   (TD),
        .SHOW_DIV   (SD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .press    (press),
        .load_msd (load_msd),
        .seg      (seg),
        .busy     (busy),
        .expired  (expired),
        .score    (score)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state 0 idle, 1 counting, 2 showing score, 3 showing over
    logic [7:0] dig_g  [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    logic [7:0] over_g [5]  = '{8'h00, 8'h3F, 8'h3E, 8'h79, 8'h50};
    int         m_st, m_val, m_pre, m_cyc;
    bit         m_pq;
    logic [7:0] m_seg;

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_glyph(input int st, input int val, input int cyc);
        int slot;
        if (st == 2) begin
            slot = (cyc / SD) % (N + 1);
            if (slot == 0) return 8'h00;
            return dig_g[(val / pow10(N - slot)) % 10];
        end
        if (st == 3) return over_g[(cyc / SD) % 5];
        return 8'h40;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit rise, tick;
        int msd;
        if (rst) begin
            m_st = 0; m_val = 0; m_pre = 0; m_cyc = 0; m_pq = 1'b0; m_seg = 8'h40;
        end else begin
            rise  = press && !m_pq;
            m_seg = exp_glyph(m_st, m_val, m_cyc);
            case (m_st)
                0: if (rise) begin
                    msd   = (load_msd > 9) ? 9 : int'(load_msd);
                    m_val = msd * pow10(N - 1) + pow10(N - 1) - 1;
                    m_pre = 0;
                    m_st  = 1;
                end
                1: begin
                    tick  = (m_pre == TD - 1);
                    m_pre = tick ? 0 : m_pre + 1;
                    if (tick && m_val == 0) begin
                        m_st = 3; m_cyc = 0;
                    end else if (rise) begin
                        m_st = 2; m_cyc = 0;
                    end else if (tick) begin
                        m_val = m_val - 1;
                    end
                end
                default: if (rise) m_st = 0; else m_cyc = m_cyc + 1;
            endcase
            m_pq = press;
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("model_seg",     seg,     m_seg);
            chk("model_score",   score,   to_bcd(m_val));
            chk("model_busy",    busy,    m_st == 1);
            chk("model_expired", expired, m_st == 3);
        end
    end

    task automatic start(input logic [3:0] msd);
        load_msd = msd;
        press    = 1'b1;
        @(negedge clk);
        press    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; press = 1'b0; load_msd = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0; cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_seg", seg, 8'h40);
        chk("reset_busy", busy, 1'b0);
        chk("reset_score", score, 8'h00);

        // Countdown with borrow, then asynchronous reset mid-count
        start(4'd1);
        chk("start_score", score, 8'h19);
        chk("start_busy", busy, 1'b1);
        repeat (4) @(negedge clk);
        chk("first_tick", score, 8'h18);
        repeat (36) @(negedge clk);
        chk("borrow", score, 8'h09);
        #2 rst = 1'b1;
        #1;
        chk("midrst_seg", seg, 8'h40);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_expired", expired, 1'b0);
        chk("midrst_score", score, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Stop at 17 with a held press, scroll the score
        start(4'd1);
        repeat (8) @(negedge clk);
        chk("pre_stop", score, 8'h17);
        press = 1'b1;
        @(negedge clk);
        chk("stop_busy", busy, 1'b0);
        @(negedge clk);
        chk("score_slot0", seg, 8'h00);
        repeat (3) @(negedge clk);
        chk("score_slot1", seg, 8'h06);
        repeat (3) @(negedge clk);
        chk("score_slot2", seg, 8'h07);
        repeat (3) @(negedge clk);
        chk("score_wrap", seg, 8'h00);
        chk("held_frozen", score, 8'h17);
        press = 1'b0;
        @(negedge clk);
        press = 1'b1;
        @(negedge clk);
        press = 1'b0;
        @(negedge clk);
        chk("back_idle_seg", seg, 8'h40);

        // Expiry from 09 and the OVEr scroll
        start(4'd0);
        chk("zero_start", score, 8'h09);
        repeat (36) @(negedge clk);
        chk("reached_zero", score, 8'h00);
        repeat (4) @(negedge clk);
        chk("expired_flag", expired, 1'b1);
        @(negedge clk);
        chk("over_blank", seg, 8'h00);
        repeat (3) @(negedge clk);
        chk("over_O", seg, 8'h3F);
        repeat (3) @(negedge clk);
        chk("over_V", seg, 8'h3E);
        repeat (3) @(negedge clk);
        chk("over_E", seg, 8'h79);
        repeat (3) @(negedge clk);
        chk("over_r", seg, 8'h50);
        repeat (3) @(negedge clk);
        chk("over_wrap", seg, 8'h00);
        press = 1'b1;
        @(negedge clk);
        press = 1'b0;
        @(negedge clk);
        chk("over_exit", expired, 1'b0);

        // Press coincident with the expiry tick
        start(4'd0);
        repeat (39) @(negedge clk);
        press = 1'b1;
        @(negedge clk);
        press = 1'b0;
        chk("race_expired", expired, 1'b1);
        chk("race_busy", busy, 1'b0);
        @(negedge clk);
        press = 1'b1;
        @(negedge clk);
        press = 1'b0;
        @(negedge clk);
        chk("race_idle_seg", seg, 8'h40);

        // Clamp of an out-of-range MSD
        start(4'd12);
        chk("clamp_score", score, 8'h99);
        repeat (6) @(negedge clk);
        chk("clamp_tick", score, 8'h98);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_display_timer.md
Name: countdown_display_timer

Overview:
Parametrised reaction-timer core for the 7-segment game designs. It counts an N-digit BCD value down at a programmable tick rate after a start press. On a stop press it freezes and shows the score; on expiry it shows an "OVEr" message. Both results scroll one glyph at a time on a single 7-segment output. It sits between the top-level pin wrapper (ui_in/uo_out) and the display pins.

Parameters:
NUM_DIGITS, 4, number of BCD countdown digits (1..8).
TICK_DIV, 1000, clk cycles per countdown decrement (>=2).
SHOW_DIV, 10000000, clk cycles each glyph is held during scrolling (>=2).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
press  in  1  player button, synchronous active-high level; only rising edges act
load_msd  in  4  initial most-significant digit; values >9 clamp to 9
seg  out  8  7-segment drive, bit7=dp, bits6:0=gfedcba, active-high
busy  out  1  high while in COUNT
expired  out  1  high while in SHOW_OVER
score  out  4*NUM_DIGITS  live BCD value, MSD in top nibble

Behaviour:
- Reset (async assert, sync release): state IDLE, all digits 0, prescaler 0, slot 0, press_q 0, busy 0, expired 0, seg 0x40 (dash).
- press_rise = press & ~press_q; press_q is registered every cycle. A held press produces exactly one event.
- States:
  - IDLE: seg 0x40. On press_rise -> COUNT. Same edge: MSD <= min(load_msd, 9), other digits <= 9, prescaler <= 0.
  - COUNT: busy 1; seg 0x40.
    - Prescaler counts 0..TICK_DIV-1; tick = (prescaler == TICK_DIV-1).
    - On tick with nonzero value: BCD decrement by 1 with borrow (digit 0 -> 9, borrow to next), all digits in one cycle.
    - On tick with value all-zero: -> SHOW_OVER; digits stay 0.
    - On press_rise: -> SHOW_SCORE; digits freeze at their current value, no decrement that cycle.
    - Expiry tick and press_rise in the same cycle: SHOW_OVER wins.
  - SHOW_SCORE: slots 0..NUM_DIGITS cycle. Slot 0 = blank (0x00); slot k = digit glyph of digit NUM_DIGITS-k (MSD first). After the last slot, wrap to 0.
  - SHOW_OVER: expired 1. Five slots: blank, O (0x3F), V (0x3E), E (0x79), r (0x50), then wrap. Independent of NUM_DIGITS.
  - SHOW_SCORE/SHOW_OVER: on press_rise -> IDLE (digits retained, slot <= 0).
- Slot timer: counts 0..SHOW_DIV-1; advances the slot when it reaches SHOW_DIV-1. It resets to 0 and slot to 0 on every entry to a SHOW state. The first glyph (blank) is held exactly SHOW_DIV cycles.
- seg is registered: it reflects the state/slot one cycle after they change.
- Digit glyphs: 0 0x3F, 1 0x06, 2 0x5B, 3 0x4F, 4 0x66, 5 0x6D, 6 0x7D, 7 0x07, 8 0x7F, 9 0x6F. Any non-BCD nibble drives 0x80 (dp only, error marker).
- Counter widths: $clog2 of the divider, with no overflow beyond DIV-1.
- Reset mid-operation: immediate return to reset values, regardless of state.

Decomposition:
- Package countdown_pkg: state enum (IDLE, COUNT, SHOW_SCORE, SHOW_OVER), glyph constants (G_BLANK, G_DASH, G_O, G_V, G_E, G_R, G_ERR), digit-glyph lookup function.
- Sub-module bcd_down_counter (parametrised NUM_DIGITS; load, dec, is_zero, value). The top holds the FSM, prescaler, slot sequencer and seg register.

Test Plan (NUM_DIGITS=2, TICK_DIV=4, SHOW_DIV=3):
- Reset: assert rst mid-COUNT -> seg=0x40, busy=0, expired=0, score=0x00 immediately.
- Start with load_msd=1 -> score=0x19, busy=1. After 4 cycles score=0x18. After 40 cycles total score=0x09 (borrow check).
- Stop press at score=0x17 -> SHOW_SCORE. seg sequence, each held 3 cycles: 0x00, 0x06, 0x07, then wraps to 0x00. A held press gives no further transition.
- load_msd=0 with countdown to 0x00 -> next tick enters SHOW_OVER, expired=1. seg cycles 0x00, 0x3F, 0x3E, 0x79, 0x50.
- press_rise on the same cycle as the expiry tick -> SHOW_OVER, not SHOW_SCORE. A following press -> IDLE, seg=0x40.
- load_msd=12 -> clamps, score=0x99 at start.
